// File: rtl/aes_pkg.sv
// AES S-box constants shared by the substitution engine: forward and inverse FIPS-197 tables.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int TAG_W = 4;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane, zero latency, no flow control of its own.
// The inverse table exists only when AES_SBOX_INV_EN is defined; otherwise inv_i is ignored.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  byte_t data_i,
  input  logic  inv_i,
  output byte_t data_o
);

`ifdef AES_SBOX_INV_EN
  assign data_o = inv_i ? SBOX_INV[data_i] : SBOX_FWD[data_i];
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign data_o     = SBOX_FWD[data_i];
`endif

endmodule

// File: rtl/aes_sbox_pipe.sv
// LANES-wide AES SubBytes/InvSubBytes engine, STAGES (1 or 2) cycles of latency, valid/ready with
// in_ready = !full | out_ready so a full pipe still streams at one beat/cycle; inverse needs AES_SBOX_INV_EN.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  logic [8*LANES-1:0] lk_in;
  logic [8*LANES-1:0] lk_out;
  logic               lk_inv;
  logic               up_vld;
  logic [TAG_W-1:0]   up_tag;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .data_i (lk_in[8*i +: 8]),
      .inv_i  (lk_inv),
      .data_o (lk_out[8*i +: 8])
    );
  end

  // Output stage: always holds the looked-up bytes, whatever STAGES is.
  logic               out_vld_q, out_vld_d;
  logic [8*LANES-1:0] out_dat_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               out_rdy;

  assign out_rdy = !out_vld_q || out_ready;

  always_comb begin
    out_vld_d = out_vld_q;
    if (out_rdy) out_vld_d = up_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_tag_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      if (out_rdy && up_vld) begin
        out_dat_q <= lk_out;
        out_tag_q <= up_tag;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_tag   = out_tag_q;

  if (STAGES == 1) begin : g_one
    assign lk_in    = in_data;
    assign lk_inv   = in_inv;
    assign up_vld   = in_valid;
    assign up_tag   = in_tag;
    assign in_ready = out_rdy;
    assign busy     = out_vld_q;
  end else begin : g_two
    // Input stage registers raw bytes so the table lookup starts from a flop.
    logic               s1_vld_q, s1_vld_d;
    logic [8*LANES-1:0] s1_dat_q;
    logic               s1_inv_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               s1_rdy;

    assign s1_rdy = !s1_vld_q || out_rdy;

    always_comb begin
      s1_vld_d = s1_vld_q;
      if (s1_rdy) s1_vld_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld_q <= 1'b0;
        s1_dat_q <= '0;
        s1_inv_q <= 1'b0;
        s1_tag_q <= '0;
      end else begin
        s1_vld_q <= s1_vld_d;
        if (s1_rdy && in_valid) begin
          s1_dat_q <= in_data;
          s1_inv_q <= in_inv;
          s1_tag_q <= in_tag;
        end
      end
    end

    assign lk_in    = s1_dat_q;
    assign lk_inv   = s1_inv_q;
    assign up_vld   = s1_vld_q;
    assign up_tag   = s1_tag_q;
    assign in_ready = s1_rdy;
    assign busy     = s1_vld_q || out_vld_q;
  end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench: a 1-stage and a 2-stage 4-lane instance side by side, checked against hand-computed S-box values.
module tb_aes_sbox_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: STAGES=1
  logic        a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in_data, a_out_data;
  logic [3:0]  a_in_tag, a_out_tag;
  // Instance b: STAGES=2
  logic        b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_in_tag, b_out_tag;

  aes_sbox_pipe #(.LANES(4), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .busy(a_busy)
  );

  aes_sbox_pipe #(.LANES(4), .STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward S-box of bytes 1..8, used by the streaming test.
  logic [7:0] fwd_1_8 [8] = '{8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30};

`ifdef AES_SBOX_INV_EN
  localparam logic [31:0] INV_EXP = 32'h01ff5300;
  localparam logic [7:0]  INV_00  = 8'h52;
`else
  localparam logic [31:0] INV_EXP = 32'h104755fb;
  localparam logic [7:0]  INV_00  = 8'h63;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, rx, cyc, first_emit;
    logic acc, emt, prev_stall, saw_full;
    logic [31:0] prev_dat;
    logic [3:0]  prev_tag;
    logic [7:0]  bv;

    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = 32'h01ff5300; a_in_tag = 4'h5; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = 32'h01020304; b_in_tag = 4'h5; b_out_ready = 1'b1;

    // Reset with in_valid held high
    repeat (3) @(negedge clk);
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_busy",      {31'd0, a_busy},      32'd0);
    chk("rst_a_out_data",  a_out_data,           32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_b_busy",      {31'd0, b_busy},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("rel_a_in_ready",  {31'd0, a_in_ready},  32'd1);
    chk("rel_b_in_ready",  {31'd0, b_in_ready},  32'd1);
    chk("rel_a_out_valid", {31'd0, a_out_valid}, 32'd0);

    // Forward lookup, one cycle latency
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = 32'h01ff5300; a_in_tag = 4'ha;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("fwd_valid", {31'd0, a_out_valid}, 32'd1);
    chk("fwd_data",  a_out_data, 32'h7c16ed63);
    chk("fwd_tag",   {28'd0, a_out_tag}, 32'ha);
    chk("fwd_busy",  {31'd0, a_busy}, 32'd1);

    // Inverse request (forward result when inverse support is not built)
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_inv = 1'b1; a_in_data = 32'h7c16ed63; a_in_tag = 4'h3;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("inv_valid", {31'd0, a_out_valid}, 32'd1);
    chk("inv_data",  a_out_data, INV_EXP);
    chk("inv_tag",   {28'd0, a_out_tag}, 32'h3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_a_valid", {31'd0, a_out_valid}, 32'd0);
    chk("idle_a_busy",  {31'd0, a_busy}, 32'd0);

    // Mode interleave at one beat per cycle
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a_in_valid = (k < 4); a_in_inv = k[0]; a_in_data = 32'h0; a_in_tag = k[3:0];
      if (k > 0) begin
        @(negedge clk);
        bv = ((k - 1) % 2 == 1) ? INV_00 : 8'h63;
        chk("mix_valid", {31'd0, a_out_valid}, 32'd1);
        chk("mix_data",  a_out_data, {4{bv}});
        chk("mix_tag",   {28'd0, a_out_tag}, k - 1);
      end
    end

    // Back-pressure streaming on the two-stage instance
    tx = 0; rx = 0; prev_stall = 1'b0; saw_full = 1'b0; first_emit = -1;
    prev_dat = '0; prev_tag = '0;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = {4{8'd1}}; b_in_tag = 4'd1; b_out_ready = 1'b1;
    for (cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      chk("bp_busy", {31'd0, b_busy}, {31'd0, (tx - rx) != 0});
      if ((tx - rx) == 2 && !b_out_ready) begin
        chk("bp_full_in_ready", {31'd0, b_in_ready}, 32'd0);
        saw_full = 1'b1;
      end
      if (prev_stall) begin
        chk("bp_hold_valid", {31'd0, b_out_valid}, 32'd1);
        chk("bp_hold_data",  b_out_data, prev_dat);
        chk("bp_hold_tag",   {28'd0, b_out_tag}, {28'd0, prev_tag});
      end
      emt = b_out_valid && b_out_ready;
      acc = b_in_valid && b_in_ready;
      if (emt) begin
        if (first_emit < 0) first_emit = cyc;
        chk("bp_data", b_out_data, {4{fwd_1_8[rx % 8]}});
        chk("bp_tag",  {28'd0, b_out_tag}, rx + 1);
      end
      prev_stall = b_out_valid && !b_out_ready;
      prev_dat = b_out_data; prev_tag = b_out_tag;
      @(posedge clk); #1;
      if (acc) tx++;
      if (emt) rx++;
      b_in_valid  = (tx < 8);
      bv = 8'(tx + 1);
      b_in_data   = {4{bv}};
      b_in_tag    = 4'(tx + 1);
      b_out_ready = !((cyc + 1) >= 3 && (cyc + 1) <= 6);
    end
    chk("bp_first_latency", first_emit, 2);
    chk("bp_count_in",  tx, 8);
    chk("bp_count_out", rx, 8);
    chk("bp_saw_full",  {31'd0, saw_full}, 32'd1);
    b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_dup", {31'd0, b_out_valid}, 32'd0);
    end
    chk("bp_drained_busy", {31'd0, b_busy}, 32'd0);

    // Mid-stream reset with two beats in flight
    @(posedge clk); #1;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h11111111; b_in_tag = 4'h7;
    @(posedge clk); #1;
    b_in_data = 32'h22222222; b_in_tag = 4'h8;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("mr_busy_before",  {31'd0, b_busy},      32'd1);
    chk("mr_valid_before", {31'd0, b_out_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_in_rst", {31'd0, b_out_valid}, 32'd0);
    chk("mr_busy_in_rst",  {31'd0, b_busy},      32'd0);
    chk("mr_data_in_rst",  b_out_data,           32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_stale", {31'd0, b_out_valid}, 32'd0);
    end
    chk("mr_in_ready", {31'd0, b_in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
